mmio_uart_v2: RTL and testbench
===============================

# mmio_uart_v2

Memory-mapped peripheral block on the CPU data-memory path. It provides one UART with parametrised transmit and receive FIFOs, a sticky receive-overflow flag, a control register (counter freeze, serial loopback), and the cycle and instruction counters. It sits beside dmem and is selected by the address decoder through `en`. Compared with the previous generation, it adds a TX FIFO, a read-qualified RX pop, FIFO occupancy in the status register, and loopback.

## Interface
- `CPU_CLOCK_FREQ`, 50_000_000, clock frequency in Hz; passed to the uart.
- `BAUD_RATE`, 115200, serial rate; passed to the uart.
- `RX_DEPTH`, 32, RX FIFO entries; power of 2, range 2..128.
- `TX_DEPTH`, 16, TX FIFO entries; power of 2, range 2..128.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  block selected this cycle.
- `we`  in  4  byte write enables; `we==0` with `en=1` is a read access.
- `instruction_complete`  in  1  one pulse per retired instruction.
- `addr`  in  14  byte address; only `addr[7:0]` is decoded.
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational.
- `serial_in`  in  1  UART RX line.
- `serial_out`  out  1  UART TX line; idles high.

## Operation
- Register map, decoded on `addr[7:0]`:
  - **0x00 STATUS (RO)**
    - bit0: TX not full.
    - bit1: RX not empty.
    - bit2: rx_overflow (sticky).
    - bit3: TX idle, meaning the TX FIFO is empty and the uart is ready.
    - [15:8]: RX count.
    - [23:16]: TX count.
    - All other bits 0.
  - **0x04 RX_DATA (RO)**
    - Reads {24'b0, head byte}, or 0 when empty.
    - A read access pops one entry at the end of the cycle.
    - Writes to this address, and accesses to any other address, never pop.
  - **0x08 TX_DATA (WO)**
    - A write with `we[0]=1` pushes `din[7:0]`.
    - If the TX FIFO is full, the byte is dropped and no flag is set.
  - **0x0C CONTROL (RW)**
    - bit0: freeze counters.
    - bit1: loopback.
    - Writes are byte-lane gated by `we[0]`; reads return {30'b0, ctrl}.
  - **0x10 CYCLE_COUNTER (RO).**
  - **0x14 INSTRUCTION_COUNTER (RO).**
  - **0x18 RESET_COUNTER (WO)**
    - Any write (`we!=0`) sets both counters to 0 at the next edge.
  - **0x1C STATUS_CLR (WO)**
    - A write with `we[0]=1` and `din[2]=1` clears rx_overflow.
  - Unmapped addresses read 0; writes to them are ignored. `dout=0` whenever `en=0`.
- **TX drain**
  - While the TX FIFO is non-empty, the head byte is presented to uart `data_in` with `data_in_valid=1`.
  - The FIFO pops on the cycle where `data_in_valid & data_in_ready`.
- **RX fill**
  - uart `data_out_ready` is tied to 1.
  - On `data_out_valid`, the byte is pushed if the RX FIFO is not full. Otherwise it is dropped and rx_overflow is set.
- **Loopback**
  - When control bit1=1, the uart serial input is driven from its own serial output, and `serial_in` is ignored.
  - `serial_out` still toggles.
- **Counters**
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
  - The cycle counter increments every cycle.
  - The instruction counter increments on cycles where `instruction_complete=1`.
  - Both hold while freeze=1.
  - RESET_COUNTER takes priority over increment and freeze.
- The existing uart is instantiated with its reset driven by `~reset`. The FIFOs are implemented inside this block as first-word-fall-through circular buffers, with pointer width clog2(depth) and count width clog2(depth)+1.

## Timing
- **Reset (`reset=0` at an edge):**
  - FIFOs empty, counts 0.
  - rx_overflow=0, control=0, both counters 0.
  - `serial_out=1`, `dout=0` while `en=0`.
  - Reset asserted mid-transfer aborts the frame; bytes in flight are lost.
- **Read latency:** 0 cycles. `dout` is valid in the same cycle as `en`/`addr`, and the pop or update lands at the closing edge.
- **RX simultaneous push and pop:**
  - When full, both succeed; count is unchanged and there is no overflow.
  - When empty, only the push takes effect (the read returns 0).
- **TX simultaneous push and drain pop:** both succeed when full; count is unchanged.
- **rx_overflow set and clear in the same cycle:** set wins.
- **Counter values read on RESET_COUNTER write cycle:** reads return the pre-clear value. Counters read 0 the cycle after, then resume counting.
- STATUS reflects registered state, so a push or pop is visible in STATUS the cycle after it occurs.

## Test plan
- Reset, then read 0x00 → 0x0000_0009 (TX not full, TX idle). Reads of 0x10 and 0x14 immediately after reset → 0.
- Write 0x55, 0xA3, 0x0F to 0x08 with loopback=1 → three RX_DATA reads return 0x55, 0xA3, 0x0F. A fourth read returns 0, and STATUS[15:8]=0.
- Receive RX_DEPTH+1 bytes with no reads → STATUS bit2=1 and count=RX_DEPTH. A STATUS_CLR write with din=0x4 → bit2=0.
- Write TX_DEPTH+3 bytes back-to-back → TX count saturates at TX_DEPTH with excess bytes dropped. The serial_out frames decode to the accepted bytes in order.
- With freeze=1, pulse `instruction_complete` for 10 cycles → both counters are unchanged. With freeze=0, 7 pulses → instruction counter +7.
- Write to 0x18 with freeze=1 → next cycle both counters read 0. Also check that a read of 0x04 with `en=0` does not pop.

Source files
------------

// File: rtl/mmio_uart_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_v2_if
// Description : CPU data-memory bus bundle between the address decoder and
//               the mmio_uart_v2 peripheral block.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_v2_if;
  logic        en;
  logic [3:0]  we;
  logic [13:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output en, we, addr, din, input dout);
  modport slave  (input en, we, addr, din, output dout);
endinterface
`default_nettype wire

// File: rtl/mmio_uart_v2.sv
`default_nettype none
// ============================================================================
// Module      : uart / mmio_uart_v2
// Description : 8N1 UART core plus the memory-mapped wrapper with TX/RX FIFOs,
//               sticky RX overflow, control register, cycle/instr counters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115_200
) (
  input  wire        clk,
  input  wire        rst,
  input  wire  [7:0] data_in_i,
  input  wire        data_in_valid_i,
  output logic       data_in_ready_o,
  output logic [7:0] data_out_o,
  output logic       data_out_valid_o,
  input  wire        data_out_ready_i,
  input  wire        serial_in_i,
  output logic       serial_out_o
);
  localparam int          c_CPB     = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] c_CPB_M1  = 16'(c_CPB - 1);
  localparam logic [15:0] c_HALF_M1 = 16'(c_CPB / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [9:0]  tx_shift_q;
  logic [3:0]  tx_bits_q;
  logic [15:0] tx_cnt_q;
  logic [1:0]  rx_sync_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid_q, rx_valid_d;
  logic        w_rx;

  assign data_in_ready_o  = (tx_bits_q == 4'd0);
  assign serial_out_o     = tx_shift_q[0];
  assign data_out_o       = rx_shift_q;
  assign data_out_valid_o = rx_valid_q;
  assign w_rx             = rx_sync_q[1];

  // Transmitter: load a start/data/stop frame and shift it out LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_q <= 10'h3FF;
      tx_bits_q  <= 4'd0;
      tx_cnt_q   <= 16'd0;
    end else if (tx_bits_q == 4'd0) begin
      if (data_in_valid_i) begin
        tx_shift_q <= {1'b1, data_in_i, 1'b0};
        tx_bits_q  <= 4'd10;
        tx_cnt_q   <= 16'd0;
      end
    end else if (tx_cnt_q == c_CPB_M1) begin
      tx_cnt_q   <= 16'd0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      tx_bits_q  <= tx_bits_q - 4'd1;
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  // Receiver state register and input synchroniser (line idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], serial_in_i};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Receiver next state: find mid start bit, then sample each bit mid-cell.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = rx_valid_q & ~data_out_ready_i;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 16'd0;
        if (!w_rx) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == c_HALF_M1) begin
        rx_cnt_d   = 16'd0;
        rx_bit_d   = 3'd0;
        rx_state_d = w_rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == c_CPB_M1) begin
        rx_cnt_d   = 16'd0;
        rx_shift_d = {w_rx, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == c_CPB_M1) begin
        rx_cnt_d   = 16'd0;
        rx_state_d = RX_IDLE;
        if (w_rx) rx_valid_d = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end
endmodule

module mmio_uart_v2 #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int RX_DEPTH       = 32,
  parameter int TX_DEPTH       = 16
) (
  input  wire               clk,
  input  wire               reset,
  mmio_uart_v2_if.slave     bus,
  input  wire               instruction_complete_i,
  input  wire               serial_in_i,
  output logic              serial_out_o
);
  localparam int                 c_RX_PW      = $clog2(RX_DEPTH);
  localparam int                 c_TX_PW      = $clog2(TX_DEPTH);
  localparam logic [c_RX_PW:0]   c_RX_FULL    = RX_DEPTH[c_RX_PW:0];
  localparam logic [c_TX_PW:0]   c_TX_FULL    = TX_DEPTH[c_TX_PW:0];
  localparam logic [c_RX_PW-1:0] c_RX_PTR_ONE = c_RX_PW'(1);
  localparam logic [c_TX_PW-1:0] c_TX_PTR_ONE = c_TX_PW'(1);
  localparam logic [c_RX_PW:0]   c_RX_CNT_ONE = (c_RX_PW + 1)'(1);
  localparam logic [c_TX_PW:0]   c_TX_CNT_ONE = (c_TX_PW + 1)'(1);

  logic [7:0]         rx_mem_q [RX_DEPTH];
  logic [7:0]         tx_mem_q [TX_DEPTH];
  logic [c_RX_PW-1:0] rx_wr_q, rx_rd_q;
  logic [c_TX_PW-1:0] tx_wr_q, tx_rd_q;
  logic [c_RX_PW:0]   rx_count_q;
  logic [c_TX_PW:0]   tx_count_q;
  logic               rx_ovf_q;
  logic [1:0]         ctrl_q;
  logic [31:0]        cyc_q, instr_q;

  logic [7:0] w_addr, w_u_dout;
  logic       w_rd, w_wr, w_u_valid, w_u_ready, w_u_serial_in, w_u_serial_out;
  logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic       w_rx_pop, w_rx_push, w_rx_drop, w_tx_pop, w_tx_push;
  logic       w_cnt_clr, w_ovf_clr, w_unused;

  assign w_addr     = bus.addr[7:0];
  assign w_rd       = bus.en & (bus.we == 4'd0);
  assign w_wr       = bus.en & (bus.we != 4'd0);
  assign w_rx_empty = (rx_count_q == '0);
  assign w_rx_full  = (rx_count_q == c_RX_FULL);
  assign w_tx_empty = (tx_count_q == '0);
  assign w_tx_full  = (tx_count_q == c_TX_FULL);
  // A full RX FIFO still accepts a byte when the same cycle pops one.
  assign w_rx_pop   = w_rd & (w_addr == 8'h04) & ~w_rx_empty;
  assign w_rx_push  = w_u_valid & (~w_rx_full | w_rx_pop);
  assign w_rx_drop  = w_u_valid & w_rx_full & ~w_rx_pop;
  assign w_tx_pop   = ~w_tx_empty & w_u_ready;
  assign w_tx_push  = w_wr & bus.we[0] & (w_addr == 8'h08) & (~w_tx_full | w_tx_pop);
  assign w_cnt_clr  = w_wr & (w_addr == 8'h18);
  assign w_ovf_clr  = w_wr & bus.we[0] & (w_addr == 8'h1C) & bus.din[2];
  assign w_u_serial_in = ctrl_q[1] ? w_u_serial_out : serial_in_i;
  assign serial_out_o  = w_u_serial_out;
  assign w_unused      = ^{bus.addr[13:8], bus.din[31:8]};

  uart #(.CPU_CLOCK_FREQ(CPU_CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
    .clk              (clk),
    .rst              (~reset),
    .data_in_i        (tx_mem_q[tx_rd_q]),
    .data_in_valid_i  (~w_tx_empty),
    .data_in_ready_o  (w_u_ready),
    .data_out_o       (w_u_dout),
    .data_out_valid_o (w_u_valid),
    .data_out_ready_i (1'b1),
    .serial_in_i      (w_u_serial_in),
    .serial_out_o     (w_u_serial_out)
  );

  // FIFO storage: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_rx_push) rx_mem_q[rx_wr_q] <= w_u_dout;
    if (w_tx_push) tx_mem_q[tx_wr_q] <= bus.din[7:0];
  end

  // FIFO pointers/counts, overflow flag, control and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wr_q <= '0; rx_rd_q <= '0; rx_count_q <= '0;
      tx_wr_q <= '0; tx_rd_q <= '0; tx_count_q <= '0;
      rx_ovf_q <= 1'b0;
      ctrl_q   <= 2'b00;
      cyc_q    <= 32'd0;
      instr_q  <= 32'd0;
    end else begin
      if (w_rx_push) rx_wr_q <= rx_wr_q + c_RX_PTR_ONE;
      if (w_rx_pop)  rx_rd_q <= rx_rd_q + c_RX_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   rx_count_q <= rx_count_q + c_RX_CNT_ONE;
        2'b01:   rx_count_q <= rx_count_q - c_RX_CNT_ONE;
        default: ;
      endcase
      if (w_tx_push) tx_wr_q <= tx_wr_q + c_TX_PTR_ONE;
      if (w_tx_pop)  tx_rd_q <= tx_rd_q + c_TX_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   tx_count_q <= tx_count_q + c_TX_CNT_ONE;
        2'b01:   tx_count_q <= tx_count_q - c_TX_CNT_ONE;
        default: ;
      endcase
      // Set outranks clear when both happen in one cycle.
      if (w_rx_drop)      rx_ovf_q <= 1'b1;
      else if (w_ovf_clr) rx_ovf_q <= 1'b0;
      if (w_wr & bus.we[0] & (w_addr == 8'h0C)) ctrl_q <= bus.din[1:0];
      if (w_cnt_clr) begin
        cyc_q   <= 32'd0;
        instr_q <= 32'd0;
      end else if (!ctrl_q[0]) begin
        cyc_q   <= cyc_q + 32'd1;
        instr_q <= instr_q + {31'd0, instruction_complete_i};
      end
    end
  end

  // Combinational register read mux; zero when deselected or unmapped.
  always_comb begin
    bus.dout = 32'd0;
    if (bus.en) begin
      case (w_addr)
        8'h00: bus.dout = {8'd0, 8'(tx_count_q), 8'(rx_count_q), 4'd0,
                           w_tx_empty & w_u_ready, rx_ovf_q, ~w_rx_empty, ~w_tx_full};
        8'h04: bus.dout = {24'd0, w_rx_empty ? 8'd0 : rx_mem_q[rx_rd_q]};
        8'h0C: bus.dout = {30'd0, ctrl_q};
        8'h10: bus.dout = cyc_q;
        8'h14: bus.dout = instr_q;
        default: bus.dout = 32'd0;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_v2
// Description : Self-checking bench for mmio_uart_v2 with a queue-based
//               reference model of the FIFOs and a serial frame decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_v2;
  localparam int CLK_HZ   = 1_000_000;
  localparam int BAUD     = 125_000;
  localparam int CPB      = CLK_HZ / BAUD;
  localparam int RX_DEPTH = 8;
  localparam int TX_DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic instruction_complete_i = 1'b0;
  logic serial_in_i = 1'b1;
  logic serial_out_o;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] mon_q[$];

  mmio_uart_v2_if bus_if ();

  mmio_uart_v2 #(
    .CPU_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD),
    .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .bus                    (bus_if),
    .instruction_complete_i (instruction_complete_i),
    .serial_in_i            (serial_in_i),
    .serial_out_o           (serial_out_o)
  );

  always #5 clk = ~clk;

  // Serial decoder for the TX line: 8N1, LSB first, sampled mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge serial_out_o);
      repeat (CPB / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1;
        b[i] = serial_out_o;
      end
      repeat (CPB) @(posedge clk);
      #1;
      mon_q.push_back(b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus_if.en = 1'b1; bus_if.we = 4'd0; bus_if.addr = {6'd0, a}; bus_if.din = 32'd0;
    #2;
    d = bus_if.dout;
    @(posedge clk); #1;
    bus_if.en = 1'b0; bus_if.addr = 14'd0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [3:0] we, input logic [31:0] d);
    bus_if.en = 1'b1; bus_if.we = we; bus_if.addr = {6'd0, a}; bus_if.din = d;
    @(posedge clk); #1;
    bus_if.en = 1'b0; bus_if.we = 4'd0; bus_if.addr = 14'd0; bus_if.din = 32'd0;
  endtask

  task automatic wait_rx_count(input int n, output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      bus_read(8'h00, s);
      if (int'(s[15:8]) == n) ok = 1'b1;
    end
  endtask

  task automatic wait_tx_idle(output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      bus_read(8'h00, s);
      if (s[3]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    bus_if.en = 1'b0; bus_if.we = 4'd0; bus_if.addr = 14'd0; bus_if.din = 32'd0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    n_vec++;
    if (serial_out_o !== 1'b1) begin n_err++; $display("FAIL reset_serial_out: got %b expected 1", serial_out_o); end
    n_vec++;
    if (bus_if.dout !== 32'd0) begin n_err++; $display("FAIL reset_dout_en0: got %h expected 0", bus_if.dout); end
    bus_read(8'h10, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL reset_cycle_cnt: got %h expected 0", d); end
    bus_read(8'h14, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL reset_instr_cnt: got %h expected 0", d); end
    bus_read(8'h00, d);
    n_vec++;
    if (d !== 32'h9) begin n_err++; $display("FAIL reset_status: got %h expected 00000009", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    logic [7:0]  exp_q[$];
    bit ok;
    bus_write(8'h0C, 4'b0001, 32'h2);
    serial_in_i = 1'b0;
    bus_write(8'h0C, 4'b1110, 32'h3);
    bus_read(8'h0C, d);
    n_vec++;
    if (d !== 32'h2) begin n_err++; $display("FAIL ctrl_lane_gate: got %h expected 00000002", d); end
    exp_q = '{8'h55, 8'hA3, 8'h0F};
    foreach (exp_q[i]) bus_write(8'h08, 4'b0001, {24'hFFFFFF, exp_q[i]});
    wait_rx_count(3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL loopback_wait: got timeout expected 3 bytes"); end
    for (int i = 0; i < 3; i++) begin
      bus_read(8'h04, d);
      n_vec++;
      if (d !== {24'd0, exp_q[i]}) begin n_err++; $display("FAIL loopback_rx%0d: got %h expected %h", i, d, exp_q[i]); end
    end
    bus_read(8'h04, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL rx_empty_read: got %h expected 0", d); end
    bus_read(8'h00, d);
    n_vec++;
    if (d[15:8] !== 8'd0) begin n_err++; $display("FAIL rx_count_zero: got %0d expected 0", d[15:8]); end
  endtask

  task automatic test_random_loopback();
    logic [31:0] d;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    bit ok;
    for (int i = 0; i < TX_DEPTH + 1; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(8'h08, 4'b0001, {24'd0, b});
    end
    wait_rx_count(TX_DEPTH + 1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rand_loop_wait: got timeout expected %0d bytes", TX_DEPTH + 1); end
    while (exp_q.size() > 0) begin
      bus_read(8'h04, d);
      n_vec++;
      if (d !== {24'd0, exp_q[0]}) begin n_err++; $display("FAIL rand_loop_rx: got %h expected %h", d, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d, exp_s;
    logic [7:0]  model_q[$];
    logic [7:0]  b;
    bit ovf = 1'b0;
    bit ok;
    for (int burst = 0; burst < 2; burst++) begin
      for (int i = 0; i < (burst == 0 ? TX_DEPTH + 1 : RX_DEPTH - TX_DEPTH); i++) begin
        b = 8'($urandom);
        if (model_q.size() < RX_DEPTH) model_q.push_back(b);
        else ovf = 1'b1;
        bus_write(8'h08, 4'b0001, {24'd0, b});
      end
      wait_tx_idle(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL ovf_tx_idle: got timeout expected idle"); end
    end
    repeat (3 * CPB) @(posedge clk);
    #1;
    exp_s = {16'd0, 8'(model_q.size()), 4'd0, 1'b1, ovf, 1'b1, 1'b1};
    bus_read(8'h00, d);
    n_vec++;
    if (d !== exp_s) begin n_err++; $display("FAIL ovf_status: got %h expected %h", d, exp_s); end
    bus_write(8'h1C, 4'b0001, 32'h0);
    bus_read(8'h00, d);
    n_vec++;
    if (d[2] !== 1'b1) begin n_err++; $display("FAIL ovf_clr_din0: got %b expected 1", d[2]); end
    bus_write(8'h1C, 4'b0001, 32'h4);
    exp_s[2] = 1'b0;
    bus_read(8'h00, d);
    n_vec++;
    if (d !== exp_s) begin n_err++; $display("FAIL ovf_cleared: got %h expected %h", d, exp_s); end
    while (model_q.size() > 0) begin
      bus_read(8'h04, d);
      n_vec++;
      if (d !== {24'd0, model_q[0]}) begin n_err++; $display("FAIL ovf_rx_data: got %h expected %h", d, model_q[0]); end
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_no_pop_when_disabled();
    logic [31:0] d;
    logic [7:0]  b;
    bit ok;
    b = 8'($urandom);
    bus_write(8'h08, 4'b0001, {24'd0, b});
    wait_rx_count(1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL nopop_wait: got timeout expected 1 byte"); end
    bus_if.en = 1'b0; bus_if.we = 4'd0; bus_if.addr = 14'h04;
    #2;
    n_vec++;
    if (bus_if.dout !== 32'd0) begin n_err++; $display("FAIL nopop_dout: got %h expected 0", bus_if.dout); end
    @(posedge clk); #1;
    bus_if.addr = 14'd0;
    bus_read(8'h00, d);
    n_vec++;
    if (d[15:8] !== 8'd1) begin n_err++; $display("FAIL nopop_count: got %0d expected 1", d[15:8]); end
    bus_read(8'h04, d);
    n_vec++;
    if (d !== {24'd0, b}) begin n_err++; $display("FAIL nopop_data: got %h expected %h", d, b); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  acc_q[$];
    logic [7:0]  b;
    bit ok;
    bus_write(8'h0C, 4'b0001, 32'h0);
    serial_in_i = 1'b1;
    mon_q.delete();
    // The first byte moves straight into the idle uart, then TX_DEPTH fill the FIFO.
    for (int i = 0; i < TX_DEPTH + 3; i++) begin
      b = 8'($urandom);
      if (i < TX_DEPTH + 1) acc_q.push_back(b);
      bus_write(8'h08, 4'b0001, {24'd0, b});
    end
    bus_read(8'h00, d);
    n_vec++;
    if (d[23:16] !== 8'(TX_DEPTH) || d[0] !== 1'b0) begin
      n_err++; $display("FAIL tx_saturate: got count %0d notfull %b expected %0d 0", d[23:16], d[0], TX_DEPTH);
    end
    wait_tx_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL tx_drain_wait: got timeout expected idle"); end
    repeat (2 * CPB) @(posedge clk);
    #1;
    n_vec++;
    if (mon_q.size() != acc_q.size()) begin
      n_err++; $display("FAIL tx_frame_count: got %0d expected %0d", mon_q.size(), acc_q.size());
    end
    for (int i = 0; i < acc_q.size() && i < mon_q.size(); i++) begin
      n_vec++;
      if (mon_q[i] !== acc_q[i]) begin n_err++; $display("FAIL tx_frame%0d: got %h expected %h", i, mon_q[i], acc_q[i]); end
    end
    bus_read(8'h00, d);
    n_vec++;
    if (d !== 32'h9) begin n_err++; $display("FAIL tx_final_status: got %h expected 00000009", d); end
  endtask

  task automatic test_counters();
    logic [31:0] c0, i0, d;
    int n, k;
    bit p;
    bus_write(8'h0C, 4'b0001, 32'h1);
    bus_read(8'h10, c0);
    bus_read(8'h14, i0);
    instruction_complete_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 instruction_complete_i = 1'b0;
    bus_read(8'h10, d);
    n_vec++;
    if (d !== c0) begin n_err++; $display("FAIL freeze_cycle: got %h expected %h", d, c0); end
    bus_read(8'h14, d);
    n_vec++;
    if (d !== i0) begin n_err++; $display("FAIL freeze_instr: got %h expected %h", d, i0); end
    bus_write(8'h0C, 4'b0001, 32'h0);
    bus_read(8'h14, i0);
    instruction_complete_i = 1'b1;
    repeat (7) @(posedge clk);
    #1 instruction_complete_i = 1'b0;
    bus_read(8'h14, d);
    n_vec++;
    if (d !== i0 + 32'd7) begin n_err++; $display("FAIL instr_plus7: got %h expected %h", d, i0 + 32'd7); end
    bus_read(8'h14, i0);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      p = 1'($urandom_range(0, 1));
      instruction_complete_i = p;
      k += int'(p);
      @(posedge clk); #1;
    end
    instruction_complete_i = 1'b0;
    bus_read(8'h14, d);
    n_vec++;
    if (d !== i0 + 32'(k)) begin n_err++; $display("FAIL instr_random: got %h expected %h", d, i0 + 32'(k)); end
    bus_read(8'h10, c0);
    n = $urandom_range(5, 50);
    repeat (n) @(posedge clk);
    #1;
    bus_read(8'h10, d);
    n_vec++;
    if (d !== c0 + 32'(n + 1)) begin n_err++; $display("FAIL cycle_delta: got %h expected %h", d, c0 + 32'(n + 1)); end
  endtask

  task automatic test_reset_counter();
    logic [31:0] d, c0;
    int n;
    bus_write(8'h0C, 4'b0001, 32'h1);
    bus_write(8'h18, 4'b0100, 32'h0);
    bus_read(8'h10, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL rstcnt_frozen_cycle: got %h expected 0", d); end
    bus_read(8'h14, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL rstcnt_frozen_instr: got %h expected 0", d); end
    bus_write(8'h0C, 4'b0001, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    bus_write(8'h18, 4'b1000, 32'h0);
    bus_read(8'h10, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL rstcnt_running_cycle: got %h expected 0", d); end
    bus_read(8'h10, c0);
    n_vec++;
    if (c0 !== 32'd1) begin n_err++; $display("FAIL rstcnt_resume: got %h expected 1", c0); end
    n = $urandom_range(3, 30);
    repeat (n) @(posedge clk);
    #1;
    bus_read(8'h10, d);
    n_vec++;
    if (d !== c0 + 32'(n + 1)) begin n_err++; $display("FAIL rstcnt_count_on: got %h expected %h", d, c0 + 32'(n + 1)); end
  endtask

  initial begin
    bus_if.en = 1'b0; bus_if.we = 4'd0; bus_if.addr = 14'd0; bus_if.din = 32'd0;
    test_reset();
    test_loopback();
    test_random_loopback();
    test_rx_overflow();
    test_no_pop_when_disabled();
    test_back_to_back();
    test_counters();
    test_reset_counter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
